// File: rtl/layer1_result_collector_pkg.sv
// Shared widths and phase constants for the layer-1 result collector.
package layer1_result_collector_pkg;

  localparam int WORD_W     = 16;
  localparam int ASM_NUM    = 8;
  localparam int GROUP_W    = 2 * WORD_W;
  localparam int FIFO_DEPTH = 2;

  // Producer runs a 4-phase cycle; each word is presented for two phases.
  typedef logic [1:0] phase_t;

  localparam phase_t PH_A_CAP = 2'd2;  // first phase of word A
  localparam phase_t PH_B_CAP = 2'd0;  // first phase of word B

endpackage

// File: rtl/layer1_group_fifo.sv
// Small FIFO holding packed result groups; head is presented combinationally.
module layer1_group_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          wr_en, rd_en;

  assign full_o  = (count_q == (AW + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  // A pop frees the slot on the same edge, so a push into a full FIFO is accepted then.
  assign wr_en   = push_i && (!full_o || pop_i);
  assign rd_en   = pop_i && !empty_o;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Storage write.
  // NOTE: the data array has no reset; entries are only visible once counted valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/layer1_result_collector.sv
// Follows the producer's 4-phase word stream, pairs word A with the following
// word B into one {B,A} group and buffers groups for the layer-2 consumer.
module layer1_result_collector #(
  parameter int WORD_W  = layer1_result_collector_pkg::WORD_W,
  parameter int ASM_NUM = layer1_result_collector_pkg::ASM_NUM,
  parameter int DEPTH   = layer1_result_collector_pkg::FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  calculate_en,
  input  logic [ASM_NUM-1:0]    asm_send,
  input  logic [WORD_W-1:0]     data_in,
  output logic [2*WORD_W-1:0]   out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overflow,
  output logic [15:0]           group_cnt
);

  import layer1_result_collector_pkg::*;

  localparam int GW = 2 * WORD_W;

  logic [ASM_NUM-1:0] send_q;
  phase_t             ph_q, ph_d;
  logic               a_pend_q, a_pend_d;
  logic [WORD_W-1:0]  a_word_q, a_word_d;
  logic               push_q, push_d;
  logic [GW-1:0]      push_data_q, push_data_d;
  logic               overflow_q;
  logic [15:0]        group_cnt_q;
  logic               adv, pop, accept, fifo_full, fifo_empty;

  // The producer only moves on when every ASM has sent.
  assign adv = calculate_en && (&send_q);

  // Phase tracking and word capture; a completed group is staged one cycle.
  // NOTE: every variable gets a default first so no latch is inferred.
  always_comb begin
    ph_d        = ph_q;
    a_pend_d    = a_pend_q;
    a_word_d    = a_word_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    if (!calculate_en) begin
      ph_d     = '0;
      a_pend_d = 1'b0;
    end else if (adv) begin
      ph_d = ph_q + 2'd1;
      if (ph_q == PH_A_CAP) begin
        a_word_d = data_in;
        a_pend_d = 1'b1;
      end else if (ph_q == PH_B_CAP && a_pend_q) begin
        // B in the first round after enable is stale and has no A; skipped.
        push_d      = 1'b1;
        push_data_d = {data_in, a_word_q};
        a_pend_d    = 1'b0;
      end
    end
  end

  // Tracker, capture and push-stage registers.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      send_q      <= '0;
      ph_q        <= '0;
      a_pend_q    <= 1'b0;
      a_word_q    <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else begin
      send_q      <= asm_send;
      ph_q        <= ph_d;
      a_pend_q    <= a_pend_d;
      a_word_q    <= a_word_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
    end
  end

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign accept    = push_q && (!fifo_full || pop);

  layer1_group_fifo #(
    .W     (GW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_q),
    .data_i  (push_data_q),
    .pop_i   (pop),
    .data_o  (out_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Sticky drop flag and count of groups that made it into the buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q  <= 1'b0;
      group_cnt_q <= '0;
    end else begin
      if (push_q && !accept) overflow_q <= 1'b1;
      if (accept) group_cnt_q <= group_cnt_q + 16'd1;
    end
  end

  assign overflow  = overflow_q;
  assign group_cnt = group_cnt_q;

endmodule

// File: tb/tb_layer1_result_collector.sv
// Self-checking bench: a queue-based reference model checked every cycle,
// plus directed scenarios with literal expected groups.
module tb_layer1_result_collector;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        calculate_en = 1'b0;
  logic [7:0]  asm_send = 8'h00;
  logic [15:0] data_in = 16'h0000;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        overflow;
  logic [15:0] group_cnt;

  always #5 clk = ~clk;

  layer1_result_collector #(
    .WORD_W  (16),
    .ASM_NUM (8),
    .DEPTH   (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .calculate_en (calculate_en),
    .asm_send     (asm_send),
    .data_in      (data_in),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .overflow     (overflow),
    .group_cnt    (group_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int M_DEPTH = 2;
  logic [7:0]  m_send  = 8'h00;   // send mask as seen one cycle late
  int          m_ph    = 0;       // producer phase 0..3
  bit          m_apend = 1'b0;    // word A held, waiting for B
  logic [15:0] m_aword = 16'h0;
  bit          m_stage = 1'b0;    // complete group on its way to the buffer
  logic [31:0] m_sdata = 32'h0;
  logic [31:0] m_q[$];            // buffered groups, head first
  bit          m_ovf   = 1'b0;
  int          m_cnt   = 0;
  logic [31:0] rx[$];             // groups taken by the consumer
  bit          m_adv;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_send = 8'h00; m_ph = 0; m_apend = 1'b0; m_aword = 16'h0;
      m_stage = 1'b0; m_sdata = 32'h0; m_q.delete(); m_ovf = 1'b0; m_cnt = 0;
    end else begin
      // consumer takes the head, then the staged group tries to enter
      if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
      if (m_stage) begin
        if (m_q.size() < M_DEPTH) begin
          m_q.push_back(m_sdata);
          m_cnt = (m_cnt + 1) % 65536;
        end else begin
          m_ovf = 1'b1;
        end
      end
      m_stage = 1'b0;
      m_adv = calculate_en && (m_send == 8'hFF);
      if (!calculate_en) begin
        m_ph = 0;
        m_apend = 1'b0;
      end else if (m_adv) begin
        if (m_ph == 2) begin
          m_aword = data_in;
          m_apend = 1'b1;
        end else if (m_ph == 0 && m_apend) begin
          m_stage = 1'b1;
          m_sdata = {data_in, m_aword};
          m_apend = 1'b0;
        end
        m_ph = (m_ph + 1) % 4;
      end
      m_send = asm_send;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("out_valid", {31'd0, out_valid}, {31'd0, m_q.size() > 0});
    check("out_data", out_data, (m_q.size() > 0) ? m_q[0] : 32'h0);
    check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    check("group_cnt", {16'd0, group_cnt}, {16'd0, m_cnt[15:0]});
    if (out_valid && out_ready) rx.push_back(out_data);
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input logic en, input logic [7:0] send, input logic [15:0] d);
    calculate_en = en;
    asm_send     = send;
    data_in      = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 8'hFF, 16'h0000);
  endtask

  // First round after enable: phases 0,1 carry a stale word.
  task automatic start();
    repeat (2) cyc(1'b1, 8'hFF, 16'h9999);
  endtask

  task automatic group(input logic [15:0] a, input logic [15:0] b);
    repeat (2) cyc(1'b1, 8'hFF, a);
    repeat (2) cyc(1'b1, 8'hFF, b);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) cyc(1'b0, 8'hFF, 16'($urandom));
    rst = 1'b1;
    idle(1);
    rx.delete();
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    // T1: reset with random inputs
    rst = 1'b0;
    repeat (3) begin
      calculate_en = 1'($urandom);
      asm_send     = 8'($urandom);
      data_in      = 16'($urandom);
      out_ready    = 1'($urandom);
      @(posedge clk);
      #1;
    end
    check("t1_valid", {31'd0, out_valid}, 32'd0);
    check("t1_data", out_data, 32'h0);
    check("t1_ovf", {31'd0, overflow}, 32'd0);
    check("t1_cnt", {16'd0, group_cnt}, 32'd0);
    rst = 1'b1;
    out_ready = 1'b1;
    idle(1);
    rx.delete();

    // T2: single group, one-cycle push latency, stale first B ignored
    start();
    repeat (2) cyc(1'b1, 8'hFF, 16'h1234);
    cyc(1'b1, 8'hFF, 16'hABCD);
    check("t2_valid_at_capture", {31'd0, out_valid}, 32'd0);
    cyc(1'b1, 8'hFF, 16'hABCD);
    check("t2_valid_next", {31'd0, out_valid}, 32'd1);
    check("t2_data", out_data, 32'hABCD_1234);
    idle(3);
    check("t2_rx_count", rx.size(), 32'd1);
    check("t2_rx0", rx[0], 32'hABCD_1234);

    // T3: four groups back to back
    do_reset();
    out_ready = 1'b1;
    start();
    for (int i = 0; i < 4; i++) group(16'h1000 + 16'(i), 16'h2000 + 16'(i));
    idle(3);
    check("t3_rx_count", rx.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      check("t3_rx", rx[i], {16'h2000 + 16'(i), 16'h1000 + 16'(i)});
    check("t3_cnt", {16'd0, group_cnt}, 32'd4);
    check("t3_ovf", {31'd0, overflow}, 32'd0);

    // T4: backpressure, third group dropped
    do_reset();
    out_ready = 1'b0;
    start();
    for (int i = 0; i < 3; i++) group(16'h3000 + 16'(i), 16'h4000 + 16'(i));
    idle(3);
    check("t4_cnt", {16'd0, group_cnt}, 32'd2);
    check("t4_ovf", {31'd0, overflow}, 32'd1);
    check("t4_valid_held", {31'd0, out_valid}, 32'd1);
    check("t4_head", out_data, 32'h4000_3000);
    out_ready = 1'b1;
    idle(4);
    check("t4_rx_count", rx.size(), 32'd2);
    check("t4_rx0", rx[0], 32'h4000_3000);
    check("t4_rx1", rx[1], 32'h4001_3001);
    check("t4_empty", {31'd0, out_valid}, 32'd0);
    check("t4_ovf_sticky", {31'd0, overflow}, 32'd1);

    // T5: abort after A captured, then a clean group
    do_reset();
    out_ready = 1'b1;
    start();
    cyc(1'b1, 8'hFF, 16'h5555);
    cyc(1'b0, 8'hFF, 16'h5555);
    idle(1);
    start();
    group(16'h0F0F, 16'hF0F0);
    idle(3);
    check("t5_rx_count", rx.size(), 32'd1);
    check("t5_rx0", rx[0], 32'hF0F0_0F0F);
    check("t5_cnt", {16'd0, group_cnt}, 32'd1);

    // T6: send mask incomplete while waiting in phase 2
    do_reset();
    out_ready = 1'b1;
    cyc(1'b1, 8'hFF, 16'h9999);
    cyc(1'b1, 8'h7F, 16'h9999);
    repeat (5) cyc(1'b1, 8'h7F, 16'hEEEE);
    cyc(1'b1, 8'hFF, 16'hEEEE);
    check("t6_no_early_out", {31'd0, out_valid}, 32'd0);
    repeat (2) cyc(1'b1, 8'hFF, 16'h2468);
    repeat (2) cyc(1'b1, 8'hFF, 16'h1357);
    idle(3);
    check("t6_rx_count", rx.size(), 32'd1);
    check("t6_rx0", rx[0], 32'h1357_2468);
    check("t6_cnt", {16'd0, group_cnt}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
